// File: rtl/disp_7_seg_scan_ctrl.sv
// ============================================================================
// Module      : disp_7_seg_scan_ctrl
// Description : Avalon-MM controlled multiplexed 7-segment scanner with
//               shadowed frame data, hex/raw modes and 16-step PWM brightness.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_7_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 3125
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int                    c_PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0]  c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);
    localparam logic [2:0]            c_IDX_MAX   = 3'(NUM_DIGITS - 1);

    // Front registers (host-visible)
    logic                    r_en, r_hex;
    logic [3:0]              r_bright;
    logic [31:0]             r_hexdata;
    logic [NUM_DIGITS-1:0]   r_dpmask;
    logic [7:0]              r_raw [NUM_DIGITS];
    logic                    r_frame;

    logic                    w_en_nxt, w_hex_nxt;
    logic [3:0]              w_bright_nxt;
    logic [31:0]             w_hexdata_nxt;
    logic [NUM_DIGITS-1:0]   w_dpmask_nxt;
    logic [7:0]              w_raw_nxt [NUM_DIGITS];

    // Display-side shadow copies
    logic                    r_sh_hex;
    logic [4*NUM_DIGITS-1:0] r_sh_hexdata;
    logic [NUM_DIGITS-1:0]   r_sh_dpmask;
    logic [7:0]              r_sh_raw [NUM_DIGITS];

    logic [c_PRESC_W-1:0]    r_presc;
    logic [3:0]              r_phase;
    logic [2:0]              r_idx;

    logic                    w_wr, w_status_wr;
    logic                    w_tc, w_phase_wrap, w_idx_last, w_wrap, w_sh_load;
    logic [7:0]              w_sel_raw;
    logic                    w_sel_dp;
    logic [3:0]              w_sel_nib;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_glyph;

    assign w_wr        = chipselect & ~write_n;
    assign w_status_wr = w_wr && (address == 4'd1);

    always_comb begin
        w_en_nxt      = r_en;
        w_hex_nxt     = r_hex;
        w_bright_nxt  = r_bright;
        w_hexdata_nxt = r_hexdata;
        w_dpmask_nxt  = r_dpmask;
        w_raw_nxt     = r_raw;
        if (w_wr) begin
            case (address)
                4'd0: begin
                    w_en_nxt     = writedata[0];
                    w_hex_nxt    = writedata[1];
                    w_bright_nxt = writedata[7:4];
                end
                4'd2:    w_hexdata_nxt = writedata;
                4'd3:    w_dpmask_nxt  = writedata[NUM_DIGITS-1:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == 4'(4 + i)) w_raw_nxt[i] = writedata[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_hex     <= 1'b1;
            r_bright  <= 4'hF;
            r_hexdata <= '0;
            r_dpmask  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) r_raw[i] <= '0;
        end else begin
            r_en      <= w_en_nxt;
            r_hex     <= w_hex_nxt;
            r_bright  <= w_bright_nxt;
            r_hexdata <= w_hexdata_nxt;
            r_dpmask  <= w_dpmask_nxt;
            r_raw     <= w_raw_nxt;
        end
    end

    assign w_tc         = (r_presc == c_PRESC_MAX);
    assign w_phase_wrap = w_tc && (r_phase == 4'hF);
    assign w_idx_last   = (r_idx == c_IDX_MAX);
    assign w_wrap       = r_en && w_phase_wrap && w_idx_last;
    assign w_sh_load    = !r_en || w_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_phase <= '0;
            r_idx   <= '0;
        end else if (!r_en) begin
            r_presc <= '0;
            r_phase <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + 1'b1;
            if (w_tc)         r_phase <= r_phase + 1'b1;
            if (w_phase_wrap) r_idx   <= w_idx_last ? 3'd0 : r_idx + 3'd1;
        end
    end

    // A frame wrap beats a coincident STATUS write so no frame event is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_frame <= 1'b0;
        else if (w_wrap)      r_frame <= 1'b1;
        else if (w_status_wr) r_frame <= 1'b0;
    end

    // Shadows take the post-write values so an enabling write sees its own data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_hex     <= 1'b0;
            r_sh_hexdata <= '0;
            r_sh_dpmask  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) r_sh_raw[i] <= '0;
        end else if (w_sh_load) begin
            r_sh_hex     <= w_hex_nxt;
            r_sh_hexdata <= w_hexdata_nxt[4*NUM_DIGITS-1:0];
            r_sh_dpmask  <= w_dpmask_nxt;
            r_sh_raw     <= w_raw_nxt;
        end
    end

    always_comb begin
        w_sel_raw = '0;
        w_sel_dp  = 1'b0;
        w_sel_nib = '0;
        w_onehot  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_sel_raw   = r_sh_raw[i];
                w_sel_dp    = r_sh_dpmask[i];
                w_sel_nib   = r_sh_hexdata[4*i +: 4];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_glyph = 7'h00;
        case (w_sel_nib)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            4'hF: w_glyph = 7'h71;
            default: w_glyph = 7'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n  <= 8'hFF;
            dig_en <= '0;
        end else if (r_en && (r_phase <= r_bright)) begin
            dig_en <= w_onehot;
            seg_n  <= r_sh_hex ? ~{w_sel_dp, w_glyph} : ~w_sel_raw;
        end else begin
            seg_n  <= 8'hFF;
            dig_en <= '0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0:    readdata = {24'd0, r_bright, 2'b00, r_hex, r_en};
            4'd1:    readdata = {23'd0, r_frame, 5'd0, r_idx};
            4'd2:    readdata = r_hexdata;
            4'd3:    readdata[NUM_DIGITS-1:0] = r_dpmask;
            default: ;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(4 + i)) readdata[7:0] = r_raw[i];
        end
    end

endmodule

`default_nettype wire
